uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 2..256.
REQ-002 Parameter DATA_W, default 8, byte width matching receiver data_out.
REQ-003 clk_50m  input  1  single clock for all logic; rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx_ready  input  1  receiver "byte ready" level; held high until cleared.
REQ-006 rx_data  input  DATA_W  receiver data_out; valid while rx_ready=1.
REQ-007 rx_ready_clr  output  1  one-cycle pulse to receiver ready_clr.
REQ-008 rd_en  input  1  consumer pop request.
REQ-009 rd_data  output  DATA_W  head entry, show-ahead; valid while empty=0.
REQ-010 empty  output  1  no entries stored.
REQ-011 full  output  1  DEPTH entries stored.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 overflow  output  1  sticky; a received byte was dropped.
REQ-014 ovf_clr  input  1  clears overflow (and ovf_cnt when compiled in).

Function
REQ-015 Capture FSM SHALL have states IDLE, CLEAR, WAIT_LOW.
REQ-016 IDLE with rx_ready=1: push rx_data at that edge, go CLEAR.
REQ-017 CLEAR: rx_ready_clr=1 for exactly that one cycle, go WAIT_LOW.
REQ-018 WAIT_LOW: rx_ready_clr=0; stay until rx_ready=0, then IDLE; guarantees one push per received byte.
REQ-019 Push SHALL be accepted if full=0, or if full=1 and an accepted pop occurs in the same cycle.
REQ-020 Push rejected while full without pop: byte dropped, overflow set next cycle, FSM still proceeds to CLEAR.
REQ-021 Pop SHALL be accepted only when rd_en=1 and empty=0; rd_en while empty ignored, no state change.
REQ-022 Simultaneous accepted push and pop: count unchanged, both pointers advance.
REQ-023 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor go below 0.
REQ-024 Latency: byte pushed at edge N appears on rd_data with empty=0 after edge N (visible in cycle N+1).
REQ-025 rd_data SHALL update to the next entry in the cycle after an accepted pop; value undefined-but-stable when empty.
REQ-026 ovf_clr=1 SHALL clear overflow; a same-cycle new overflow event takes priority (overflow stays 1).

Reset
REQ-027 rst=1 at a clock edge: FSM to IDLE, pointers and count 0, empty=1, full=0, overflow=0, rx_ready_clr=0.
REQ-028 Reset mid-capture (CLEAR or WAIT_LOW) SHALL abandon the handshake; if rx_ready still 1 after reset, IDLE recaptures that byte.
REQ-029 Memory contents SHALL NOT require reset.

Configuration
REQ-030 Macro UART_RX_FIFO_OVF_CNT_EN defined: output ovf_cnt, 8 bits, counts dropped bytes, saturates at 255, cleared by rst or ovf_clr (increment wins over clear in same cycle, result 1).
REQ-031 Macro undefined: ovf_cnt port and counter logic absent; all other behaviour identical.

Structure
REQ-032 Shared package uart_pkg SHALL hold DATA_W default constant and the capture FSM state enumeration.
REQ-033 Storage, pointers, count, full/empty SHALL be a sub-module uart_sync_fifo; FSM, overflow logic in uart_rx_fifo.

Verification
REQ-034 Single byte: rx_ready high with rx_data=8'hA5 -> exactly one rx_ready_clr pulse, empty=0 next cycle, rd_data=8'hA5, count=1.
REQ-035 Stuck ready: rx_ready held high 10 cycles with 8'h3C -> only one push, count=1, one rx_ready_clr pulse.
REQ-036 Fill/wrap: push 8'h00..8'h0F (DEPTH=16) -> full=1, count=16; pop 16 -> data in order 00..0F, empty=1; repeat 20 bytes interleaved, order preserved across wrap.
REQ-037 Overflow: full FIFO, push 8'hFF without pop -> byte dropped, overflow=1, rx_ready_clr still pulses, ovf_cnt=1 (macro on); ovf_clr -> overflow=0.
REQ-038 Full plus simultaneous pop/push 8'h77 -> count stays 16, head advances, 8'h77 last out.
REQ-039 Reset in WAIT_LOW with rx_ready=1, rx_data=8'h5A -> after reset count=0, then recapture gives count=1, rd_data=8'h5A.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive FIFO slice.
//   DATA_W_DEFAULT : default byte width of the receiver data path.
//   cap_state_e    : capture FSM states (IDLE, CLEAR, WAIT_LOW).
package uart_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StClear   = 2'd1,
        StWaitLow = 2'd2
    } cap_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock show-ahead FIFO with occupancy count.
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset (pointers and count only)
//   push_i     : push request, wdata_i written when accepted
//   wdata_i    : data to push
//   pop_i      : pop request, ignored while empty
//   rdata_o    : head entry, valid while empty_o = 0
//   empty_o    : no entries stored
//   full_o     : DEPTH entries stored
//   count_o    : current occupancy, 0..DEPTH
//   push_acc_o : push accepted this cycle
module uart_sync_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       push_acc_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              pop_acc, push_acc;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign pop_acc    = pop_i && !empty_o;
    // A full FIFO can still take a push when a pop frees the head slot in the same cycle.
    assign push_acc   = push_i && (!full_o || pop_acc);
    assign push_acc_o = push_acc;
    assign count_o    = count_q;
    assign rdata_o    = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_acc)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage carries no reset; empty_o qualifies the head value.
    always_ff @(posedge clk_i) begin
        if (push_acc) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures bytes from a UART receiver's ready/ready_clr handshake into a FIFO.
// Ports:
//   clk_50m      : clock, rising edge
//   rst          : synchronous active-high reset
//   rx_ready     : receiver byte-ready level, held until cleared
//   rx_data      : receiver byte, valid while rx_ready = 1
//   rx_ready_clr : one-cycle pulse back to the receiver
//   rd_en        : consumer pop request
//   rd_data      : head entry (show-ahead), valid while empty = 0
//   empty, full  : FIFO status
//   count        : FIFO occupancy
//   overflow     : sticky, a received byte was dropped
//   ovf_clr      : clears overflow (and ovf_cnt)
//   ovf_cnt      : saturating dropped-byte counter, present only when
//                  UART_RX_FIFO_OVF_CNT_EN is defined
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                   clk_50m,
    input  logic                   rst,
    input  logic                   rx_ready,
    input  logic [DATA_W-1:0]      rx_data,
    output logic                   rx_ready_clr,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   ovf_clr
`ifdef UART_RX_FIFO_OVF_CNT_EN
    ,
    output logic [7:0]             ovf_cnt
`endif
);

    cap_state_e state_q;
    logic       rx_ready_clr_q;
    logic       overflow_q;
    logic       push, push_acc, drop;

    // A byte is taken only on entry to the handshake, so a stuck rx_ready yields one push.
    assign push = (state_q == StIdle) && rx_ready;
    assign drop = push && !push_acc;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_i      (clk_50m),
        .rst_i      (rst),
        .push_i     (push),
        .wdata_i    (rx_data),
        .pop_i      (rd_en),
        .rdata_o    (rd_data),
        .empty_o    (empty),
        .full_o     (full),
        .count_o    (count),
        .push_acc_o (push_acc)
    );

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q        <= StIdle;
            rx_ready_clr_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rx_ready) begin
                        state_q        <= StClear;
                        rx_ready_clr_q <= 1'b1;
                    end
                end
                StClear: begin
                    state_q        <= StWaitLow;
                    rx_ready_clr_q <= 1'b0;
                end
                StWaitLow: begin
                    if (!rx_ready) state_q <= StIdle;
                end
                default: begin
                    state_q        <= StIdle;
                    rx_ready_clr_q <= 1'b0;
                end
            endcase
        end
    end

    // A new drop outranks a same-cycle clear.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign rx_ready_clr = rx_ready_clr_q;
    assign overflow     = overflow_q;

`ifdef UART_RX_FIFO_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;

    // Clear-then-increment when both happen, giving 1.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else if (drop) begin
            if (ovf_clr)                ovf_cnt_q <= 8'd1;
            else if (ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end else if (ovf_clr) begin
            ovf_cnt_q <= '0;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scenarios with literal expectations, then randomized receiver and
// consumer traffic, all checked every cycle against a queue-based behavioural model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int CW    = 5;

    logic          clk_50m = 1'b0;
    logic          rst, rx_ready, rd_en, ovf_clr;
    logic [DW-1:0] rx_data;
    logic          rx_ready_clr, empty, full, overflow;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] count;
`ifdef UART_RX_FIFO_OVF_CNT_EN
    logic [7:0]    ovf_cnt;
`endif

    always #5 clk_50m = ~clk_50m;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DW)
    ) dut (
        .clk_50m      (clk_50m),
        .rst          (rst),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_ready_clr (rx_ready_clr),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr)
`ifdef UART_RX_FIFO_OVF_CNT_EN
        ,
        .ovf_cnt      (ovf_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a byte queue, sticky flag, drop counter and a handshake phase
    // (0 = ready to take a byte, 1 = clear pulse cycle, 2 = waiting for ready to fall).
    logic [DW-1:0] m_q[$];
    bit            m_ovf   = 1'b0;
    int            m_cnt   = 0;
    int            m_phase = 0;
    bit            m_valid = 1'b0;

    always @(posedge clk_50m) begin : model
        bit pop, push, acc;
        if (rst) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_cnt   = 0;
            m_phase = 0;
            m_valid = 1'b1;
        end else begin
            pop  = rd_en && (m_q.size() > 0);
            push = (m_phase == 0) && rx_ready;
            acc  = push && ((m_q.size() < DEPTH) || pop);
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(rx_data);
            if (push && !acc) begin
                m_ovf = 1'b1;
                m_cnt = ovf_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            end else if (ovf_clr) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end
            case (m_phase)
                0:       if (rx_ready) m_phase = 1;
                1:       m_phase = 2;
                default: if (!rx_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk_50m) begin
        if (rx_ready_clr === 1'b1) pulses++;
        if (m_valid) begin
            chk("model_rx_ready_clr", rx_ready_clr, m_phase == 1);
            chk("model_empty", empty, m_q.size() == 0);
            chk("model_full", full, m_q.size() == DEPTH);
            chk("model_count", count, m_q.size());
            chk("model_overflow", overflow, m_ovf);
            if (m_q.size() > 0) chk("model_rd_data", rd_data, m_q[0]);
`ifdef UART_RX_FIFO_OVF_CNT_EN
            chk("model_ovf_cnt", ovf_cnt, m_cnt);
`endif
        end
    end

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic push_byte(input logic [DW-1:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic pop_check(input string name, input logic [DW-1:0] exp);
        chk(name, rd_data, exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    int          rel = -1;
    int unsigned pop_pct = 50;
    logic [DW-1:0] exp_next;

    initial begin
        rst      = 1'b1;
        rx_ready = 1'b0;
        rx_data  = '0;
        rd_en    = 1'b0;
        ovf_clr  = 1'b0;
        tick();
        rst = 1'b0;
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_count", count, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_clr", rx_ready_clr, 0);

        // Single byte
        pulses   = 0;
        rx_ready = 1'b1;
        rx_data  = 8'hA5;
        tick();
        chk("single_clr", rx_ready_clr, 1);
        chk("single_empty", empty, 0);
        chk("single_data", rd_data, 8'hA5);
        chk("single_count", count, 1);
        rx_ready = 1'b0;
        tick();
        chk("single_clr_low", rx_ready_clr, 0);
        tick();
        chk("single_pulses", pulses, 1);
        pop_check("single_pop", 8'hA5);

        // Stuck ready
        pulses   = 0;
        rx_ready = 1'b1;
        rx_data  = 8'h3C;
        repeat (10) tick();
        rx_ready = 1'b0;
        tick();
        tick();
        chk("stuck_count", count, 1);
        chk("stuck_pulses", pulses, 1);
        pop_check("stuck_data", 8'h3C);

        // Fill and wrap
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        for (int i = 0; i < 16; i++) pop_check("fill_order", 8'(i));
        chk("drain_empty", empty, 1);
        exp_next = 8'h40;
        for (int i = 0; i < 20; i++) begin
            push_byte(8'(8'h40 + i));
            if (i % 2 == 1) begin
                pop_check("wrap_order", exp_next);
                exp_next = exp_next + 8'd1;
            end
        end
        for (int i = 0; i < 10; i++) begin
            pop_check("wrap_order", exp_next);
            exp_next = exp_next + 8'd1;
        end
        chk("wrap_empty", empty, 1);

        // Overflow
        for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
        pulses = 0;
        push_byte(8'hFF);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 16);
        chk("ovf_pulses", pulses, 1);
        chk("ovf_head", rd_data, 8'h80);
`ifdef UART_RX_FIFO_OVF_CNT_EN
        chk("ovf_cnt_one", ovf_cnt, 1);
`endif
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);
`ifdef UART_RX_FIFO_OVF_CNT_EN
        chk("ovf_cnt_cleared", ovf_cnt, 0);
`endif

        // Full with simultaneous pop and push
        rd_en    = 1'b1;
        rx_ready = 1'b1;
        rx_data  = 8'h77;
        tick();
        rd_en    = 1'b0;
        rx_ready = 1'b0;
        chk("fullpp_count", count, 16);
        chk("fullpp_head", rd_data, 8'h81);
        chk("fullpp_ovf", overflow, 0);
        tick();
        tick();
        for (int i = 1; i < 16; i++) pop_check("fullpp_order", 8'(8'h80 + i));
        pop_check("fullpp_last", 8'h77);
        chk("fullpp_empty", empty, 1);

        // Reset while waiting for ready to fall
        rx_ready = 1'b1;
        rx_data  = 8'h5A;
        tick();
        tick();
        chk("rstmid_pre_count", count, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_count", count, 0);
        chk("rstmid_empty", empty, 1);
        tick();
        chk("rstmid_recap_count", count, 1);
        chk("rstmid_recap_data", rd_data, 8'h5A);
        rx_ready = 1'b0;
        tick();
        tick();

        // Randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 250 == 0) pop_pct = $urandom_range(5, 90);
            rd_en   = ($urandom_range(0, 99) < pop_pct);
            ovf_clr = ($urandom_range(0, 31) == 0);
            rst     = ($urandom_range(0, 599) == 0);
            if (!rx_ready) begin
                if ($urandom_range(0, 2) == 0) begin
                    rx_ready = 1'b1;
                    rx_data  = 8'($urandom);
                end
            end else if (rel >= 0) begin
                if (rel == 0) begin
                    rx_ready = 1'b0;
                    rel      = -1;
                end else begin
                    rel--;
                end
            end else if (rx_ready_clr === 1'b1) begin
                rel = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(0, 3));
            end
            tick();
        end
        rst      = 1'b0;
        rd_en    = 1'b0;
        ovf_clr  = 1'b0;
        rx_ready = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
